// File: rtl/clint_reg2axi.sv
// Single-outstanding AXI4 initiator: turns one valid/ready register request into a single-beat
// AXI4 read or write. Optional macro CLINT_REG2AXI_ID_CHECK_EN flags responses with a foreign BID/RID.
module clint_reg2axi #(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_ID_W   = 8,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_ID_VAL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  // register request / response port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [AXI_ADDR_W-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  // AW
  output logic                  slv_awvalid,
  output logic [AXI_ADDR_W-1:0] slv_awaddr,
  output logic [7:0]            slv_awlen,
  output logic [2:0]            slv_awsize,
  output logic [1:0]            slv_awburst,
  output logic                  slv_awlock,
  output logic [3:0]            slv_awcache,
  output logic [2:0]            slv_awprot,
  output logic [3:0]            slv_awqos,
  output logic [3:0]            slv_awregion,
  output logic [AXI_ID_W-1:0]   slv_awid,
  input  logic                  slv_awready,
  // W
  output logic                  slv_wvalid,
  output logic [31:0]           slv_wdata,
  output logic [3:0]            slv_wstrb,
  output logic                  slv_wlast,
  input  logic                  slv_wready,
  // B
  input  logic                  slv_bvalid,
  output logic                  slv_bready,
  input  logic [AXI_ID_W-1:0]   slv_bid,
  input  logic [1:0]            slv_bresp,
  // AR
  output logic                  slv_arvalid,
  output logic [AXI_ADDR_W-1:0] slv_araddr,
  output logic [7:0]            slv_arlen,
  output logic [2:0]            slv_arsize,
  output logic [1:0]            slv_arburst,
  output logic                  slv_arlock,
  output logic [3:0]            slv_arcache,
  output logic [2:0]            slv_arprot,
  output logic [3:0]            slv_arqos,
  output logic [3:0]            slv_arregion,
  output logic [AXI_ID_W-1:0]   slv_arid,
  input  logic                  slv_arready,
  // R
  input  logic                  slv_rvalid,
  output logic                  slv_rready,
  input  logic [AXI_ID_W-1:0]   slv_rid,
  input  logic [1:0]            slv_rresp,
  input  logic [31:0]           slv_rdata,
  input  logic                  slv_rlast
);

  if (!((AXI_ADDR_W == 32) || (AXI_ADDR_W == 64))) begin : g_bad_addr_w
    $error("clint_reg2axi: AXI_ADDR_W must be 32 or 64");
  end
  if (AXI_DATA_W != 32) begin : g_bad_data_w
    $error("clint_reg2axi: AXI_DATA_W must be 32");
  end

  // IDLE wait request | WR AW+W in flight | B wait BRESP | AR addr in flight | R wait RDATA | RSP hold response
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_B    = 3'd2,
    S_AR   = 3'd3,
    S_R    = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  localparam logic [AXI_ID_W-1:0] ID_VAL = AXI_ID_W'(AXI_ID_VAL);

  state_t                state_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                  rsp_valid_q, rsp_err_q;
  logic [31:0]           rsp_rdata_q;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;

  logic aw_done, w_done, b_id_err, r_id_err;

  // a handshake happening this cycle already counts as done
  assign aw_done = ~awvalid_q | slv_awready;
  assign w_done  = ~wvalid_q  | slv_wready;

`ifdef CLINT_REG2AXI_ID_CHECK_EN
  assign b_id_err = (slv_bid != ID_VAL);
  assign r_id_err = (slv_rid != ID_VAL);
`else
  logic unused_id;
  assign unused_id = ^{slv_bid, slv_rid};
  assign b_id_err  = 1'b0;
  assign r_id_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (req_wen) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_AR;
            end
          end
        end
        S_WR: begin
          if (slv_awready) awvalid_q <= 1'b0;
          if (slv_wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= S_B;
          end
        end
        S_B: begin
          if (slv_bvalid) begin
            bready_q    <= 1'b0;
            rsp_err_q   <= slv_bresp[1] | b_id_err;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RSP;
          end
        end
        S_AR: begin
          if (slv_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (slv_rvalid) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= slv_rdata;
            rsp_err_q   <= slv_rresp[1] | ~slv_rlast | r_id_err;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign slv_awvalid  = awvalid_q;
  assign slv_awaddr   = addr_q;
  assign slv_awlen    = 8'd0;
  assign slv_awsize   = 3'b010;
  assign slv_awburst  = 2'b01;
  assign slv_awlock   = 1'b0;
  assign slv_awcache  = 4'd0;
  assign slv_awprot   = 3'd0;
  assign slv_awqos    = 4'd0;
  assign slv_awregion = 4'd0;
  assign slv_awid     = ID_VAL;

  assign slv_wvalid = wvalid_q;
  assign slv_wdata  = wdata_q;
  assign slv_wstrb  = wstrb_q;
  assign slv_wlast  = 1'b1;

  assign slv_bready = bready_q;

  assign slv_arvalid  = arvalid_q;
  assign slv_araddr   = addr_q;
  assign slv_arlen    = 8'd0;
  assign slv_arsize   = 3'b010;
  assign slv_arburst  = 2'b01;
  assign slv_arlock   = 1'b0;
  assign slv_arcache  = 4'd0;
  assign slv_arprot   = 3'd0;
  assign slv_arqos    = 4'd0;
  assign slv_arregion = 4'd0;
  assign slv_arid     = ID_VAL;

  assign slv_rready = rready_q;

endmodule

// File: tb/tb_clint_reg2axi.sv
// Directed bench for clint_reg2axi: the slave side is driven by hand, expected values are constants.
module tb_clint_reg2axi;
  localparam logic [7:0] ID = 8'h3C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        awvalid, awlock, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen, awid;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic [3:0]  awcache, awqos, awregion;
  logic        wvalid, wlast, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arlock, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen, arid;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic [3:0]  arcache, arqos, arregion;
  logic        rvalid, rready, rlast;
  logic [7:0]  rid;
  logic [1:0]  rresp;
  logic [31:0] rdata;

  clint_reg2axi #(.AXI_ADDR_W(32), .AXI_ID_W(8), .AXI_DATA_W(32), .AXI_ID_VAL(32'h3C)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .slv_awvalid(awvalid), .slv_awaddr(awaddr), .slv_awlen(awlen), .slv_awsize(awsize),
    .slv_awburst(awburst), .slv_awlock(awlock), .slv_awcache(awcache), .slv_awprot(awprot),
    .slv_awqos(awqos), .slv_awregion(awregion), .slv_awid(awid), .slv_awready(awready),
    .slv_wvalid(wvalid), .slv_wdata(wdata), .slv_wstrb(wstrb), .slv_wlast(wlast), .slv_wready(wready),
    .slv_bvalid(bvalid), .slv_bready(bready), .slv_bid(bid), .slv_bresp(bresp),
    .slv_arvalid(arvalid), .slv_araddr(araddr), .slv_arlen(arlen), .slv_arsize(arsize),
    .slv_arburst(arburst), .slv_arlock(arlock), .slv_arcache(arcache), .slv_arprot(arprot),
    .slv_arqos(arqos), .slv_arregion(arregion), .slv_arid(arid), .slv_arready(arready),
    .slv_rvalid(rvalid), .slv_rready(rready), .slv_rid(rid), .slv_rresp(rresp),
    .slv_rdata(rdata), .slv_rlast(rlast)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // presents one request for the accepting edge; returns in cycle 1
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b1;
    awready = 1'b1; wready = 1'b1;
    bvalid = 1'b1; bid = ID; bresp = 2'b00;
    arready = 1'b1;
    rvalid = 1'b1; rid = ID; rresp = 2'b00; rdata = 32'h0; rlast = 1'b1;

    // reset state
    step(); step();
    chk("rst_awvalid", awvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_req_ready", req_ready, 1);
    rst = 1'b0;

    // zero-wait write
    issue(1'b1, 32'h0200_4000, 32'hDEAD_BEEF, 4'hF);
    chk("wr_awvalid", awvalid, 1);
    chk("wr_awaddr", awaddr, 32'h0200_4000);
    chk("wr_awlen", awlen, 0);
    chk("wr_awsize", awsize, 2);
    chk("wr_awburst", awburst, 1);
    chk("wr_awid", awid, 8'h3C);
    chk("wr_wvalid", wvalid, 1);
    chk("wr_wdata", wdata, 32'hDEAD_BEEF);
    chk("wr_wstrb", wstrb, 4'hF);
    chk("wr_wlast", wlast, 1);
    chk("wr_req_ready_busy", req_ready, 0);
    chk("wr_bready_c1", bready, 0);
    step();
    chk("wr_bready_c2", bready, 1);
    chk("wr_awvalid_c2", awvalid, 0);
    chk("wr_wvalid_c2", wvalid, 0);
    step();
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    step();
    chk("wr_rsp_done", rsp_valid, 0);
    chk("wr_req_ready_back", req_ready, 1);

    // zero-wait read
    rdata = 32'h1234_5678;
    issue(1'b0, 32'h0200_BFF8, 32'h0, 4'h0);
    chk("rd_arvalid", arvalid, 1);
    chk("rd_araddr", araddr, 32'h0200_BFF8);
    chk("rd_arlen", arlen, 0);
    chk("rd_arsize", arsize, 2);
    chk("rd_arid", arid, 8'h3C);
    chk("rd_rready_c1", rready, 0);
    step();
    chk("rd_rready_c2", rready, 1);
    chk("rd_arvalid_c2", arvalid, 0);
    step();
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd_rsp_err", rsp_err, 0);
    step();

    // error A: read SLVERR
    rresp = 2'b10;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    step(); step();
    chk("errA_valid", rsp_valid, 1);
    chk("errA_err", rsp_err, 1);
    step();
    rresp = 2'b00;

    // error B: write SLVERR, read data must be cleared
    bresp = 2'b10;
    issue(1'b1, 32'h0000_0020, 32'h5555_AAAA, 4'h3);
    step(); step();
    chk("errB_valid", rsp_valid, 1);
    chk("errB_err", rsp_err, 1);
    chk("errB_rdata", rsp_rdata, 0);
    step();
    bresp = 2'b00;

    // error C: read without rlast
    rlast = 1'b0;
    rdata = 32'h0BAD_F00D;
    issue(1'b0, 32'h0000_0030, 32'h0, 4'h0);
    step(); step();
    chk("errC_err", rsp_err, 1);
    chk("errC_rdata", rsp_rdata, 32'h0BAD_F00D);
    step();
    rlast = 1'b1;

    // skewed write: W accepted at once, AW accepted on the fourth cycle
    awready = 1'b0;
    issue(1'b1, 32'h0200_0008, 32'hCAFE_0001, 4'h1);
    chk("skw_c1_awvalid", awvalid, 1);
    chk("skw_c1_wvalid", wvalid, 1);
    step();
    chk("skw_c2_wvalid", wvalid, 0);
    chk("skw_c2_awvalid", awvalid, 1);
    chk("skw_c2_bready", bready, 0);
    step();
    chk("skw_c3_awvalid", awvalid, 1);
    chk("skw_c3_awaddr", awaddr, 32'h0200_0008);
    step();
    chk("skw_c4_awvalid", awvalid, 1);
    chk("skw_c4_awaddr", awaddr, 32'h0200_0008);
    chk("skw_c4_bready", bready, 0);
    awready = 1'b1;
    step();
    chk("skw_c5_bready", bready, 1);
    chk("skw_c5_awvalid", awvalid, 0);
    step();
    chk("skw_rsp_valid", rsp_valid, 1);
    chk("skw_rsp_err", rsp_err, 0);
    step();

    // response backpressure
    rsp_ready = 1'b0;
    rdata = 32'hA5A5_0F0F;
    issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 32'hA5A5_0F0F);
      chk("bp_err", rsp_err, 0);
      chk("bp_req_ready", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_req_ready_after", req_ready, 1);
    chk("bp_valid_after", rsp_valid, 0);

    // reset while waiting in R
    rvalid = 1'b0;
    issue(1'b0, 32'h0000_0050, 32'h0, 4'h0);
    step();
    chk("rstR_rready_before", rready, 1);
    rst = 1'b1;
    step();
    chk("rstR_rready", rready, 0);
    chk("rstR_rsp_valid", rsp_valid, 0);
    chk("rstR_req_ready", req_ready, 1);
    rst = 1'b0;
    rvalid = 1'b1;

    // response ID differing from the configured ID
    rid = ID + 8'd1;
    rdata = 32'h0000_7777;
    issue(1'b0, 32'h0000_0060, 32'h0, 4'h0);
    step(); step();
    chk("id_rsp_valid", rsp_valid, 1);
    chk("id_rsp_rdata", rsp_rdata, 32'h0000_7777);
`ifdef CLINT_REG2AXI_ID_CHECK_EN
    chk("id_rsp_err", rsp_err, 1);
`else
    chk("id_rsp_err", rsp_err, 0);
`endif
    step();
    rid = ID;
    chk("id_req_ready", req_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
